// File: rtl/vend_ctrl_fsm.sv
// rtl/vend_ctrl_fsm.sv - vending transaction controller: credit, dispense, change, timeout refund
// Optional sales log (o_sales_cnt/o_revenue) enabled by defining VEND_SALES_LOG_EN.
module vend_ctrl_fsm #(
  parameter int PRICE      = 700,
  parameter int CREDIT_MAX = 9900,
  parameter int TIMEOUT_S  = 10,
  parameter int DISPENSE_S = 2,
  parameter int CW         = 16
) (
  input  logic          i_clk,
  input  logic          reset,
  input  logic          i_sec,
  input  logic          i_coin100,
  input  logic          i_coin500,
  input  logic          i_cancel,
  output logic [CW-1:0] o_credit,
  output logic          o_vend,
  output logic [CW-1:0] o_change,
  output logic          o_change_valid,
  output logic          o_reject,
  output logic [1:0]    o_state,
  output logic [7:0]    o_time_left
`ifdef VEND_SALES_LOG_EN
  ,
  output logic [15:0]   o_sales_cnt,
  output logic [CW+7:0] o_revenue
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_credit;
  logic [CW-1:0] r_change;
  logic          r_vend;
  logic          r_change_valid;
  logic          r_reject;
  logic [7:0]    r_time_left;
  logic [7:0]    r_disp_cnt;
  logic          r_sec_d;

  logic          w_tick;
  logic          w_arb;
  logic [CW:0]   w_sum100;
  logic [CW:0]   w_sum500;
  logic          w_acc100;
  logic          w_acc500;
  logic          w_acc;
  logic          w_rej;
  logic [CW-1:0] w_add;

  assign w_tick = i_sec & ~r_sec_d;

  // Coins are only considered while collecting and not already leaving COLLECT this cycle.
  assign w_arb = (r_state == S_IDLE) ||
                 ((r_state == S_COLLECT) && (r_credit < CW'(PRICE)) && (r_time_left != 8'd0));

  assign w_sum100 = {1'b0, r_credit} + (CW+1)'(100);
  assign w_sum500 = {1'b0, r_credit} + (CW+1)'(500);
  assign w_acc500 = w_arb && !i_cancel && i_coin500 && (w_sum500 <= (CW+1)'(CREDIT_MAX));
  assign w_acc100 = w_arb && !i_cancel && !i_coin500 && i_coin100 &&
                    (w_sum100 <= (CW+1)'(CREDIT_MAX));
  assign w_acc    = w_acc500 | w_acc100;
  assign w_rej    = (i_coin500 && !w_acc500) || (i_coin100 && !w_acc100);
  assign w_add    = w_acc500 ? CW'(500) : CW'(100);

`ifdef VEND_SALES_LOG_EN
  logic [15:0]   r_sales_cnt;
  logic [CW+7:0] r_revenue;
  logic [CW+8:0] w_rev_sum;

  assign w_rev_sum = {1'b0, r_revenue} + (CW+9)'(PRICE);

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_sales_cnt <= '0;
      r_revenue   <= '0;
    end else if (r_state == S_COLLECT && r_credit >= CW'(PRICE)) begin
      if (r_sales_cnt != 16'hFFFF) r_sales_cnt <= r_sales_cnt + 16'd1;
      r_revenue <= w_rev_sum[CW+8] ? '1 : w_rev_sum[CW+7:0];
    end
  end

  assign o_sales_cnt = r_sales_cnt;
  assign o_revenue   = r_revenue;
`endif

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_credit       <= '0;
      r_change       <= '0;
      r_vend         <= 1'b0;
      r_change_valid <= 1'b0;
      r_reject       <= 1'b0;
      r_time_left    <= '0;
      r_disp_cnt     <= '0;
      r_sec_d        <= 1'b1;
    end else begin
      r_sec_d        <= i_sec;
      r_reject       <= w_rej;
      r_change_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_state     <= S_COLLECT;
            r_credit    <= r_credit + w_add;
            r_time_left <= 8'(TIMEOUT_S);
          end
        end
        S_COLLECT: begin
          if (r_credit >= CW'(PRICE)) begin
            r_state     <= S_DISPENSE;
            r_credit    <= r_credit - CW'(PRICE);
            r_vend      <= 1'b1;
            r_disp_cnt  <= '0;
            r_time_left <= '0;
          end else if (i_cancel || r_time_left == 8'd0) begin
            r_state        <= S_CHANGE;
            r_change       <= r_credit;
            r_change_valid <= 1'b1;
            r_credit       <= '0;
            r_time_left    <= '0;
          end else if (w_acc) begin
            r_credit    <= r_credit + w_add;
            r_time_left <= 8'(TIMEOUT_S);
          end else if (w_tick) begin
            r_time_left <= r_time_left - 8'd1;
          end
        end
        S_DISPENSE: begin
          if (w_tick) begin
            if (r_disp_cnt == 8'(DISPENSE_S - 1)) begin
              r_vend <= 1'b0;
              if (r_credit != '0) begin
                r_state        <= S_CHANGE;
                r_change       <= r_credit;
                r_change_valid <= 1'b1;
                r_credit       <= '0;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_disp_cnt <= r_disp_cnt + 8'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_credit       = r_credit;
  assign o_vend         = r_vend;
  assign o_change       = r_change;
  assign o_change_valid = r_change_valid;
  assign o_reject       = r_reject;
  assign o_state        = r_state;
  assign o_time_left    = r_time_left;

endmodule
